// File: rtl/wave_prof_if.sv
// Wave-profile link between the wave calculator / display path (master) and
// the profile reader (slave). scroll_off exists only when WAVE_SCROLL_EN is defined.
interface wave_prof_if #(
  parameter int LOG_WIDTH = 10,
  parameter int RESOL     = 10
);
  logic                 wr_en;
  logic [LOG_WIDTH-1:0] wr_index;
  logic [RESOL-1:0]     wr_value;
  logic                 wave_ready;
  logic                 frame_start;
  logic                 rd_req;
  logic [LOG_WIDTH-1:0] rd_index;
  logic [RESOL-1:0]     rd_data;
  logic                 rd_valid;
  logic                 swap_pending;
  logic                 prof_valid;
  logic                 wr_drop;
`ifdef WAVE_SCROLL_EN
  logic [LOG_WIDTH-1:0] scroll_off;
`endif

  modport master (
`ifdef WAVE_SCROLL_EN
    output scroll_off,
`endif
    output wr_en, wr_index, wr_value, wave_ready, frame_start, rd_req, rd_index,
    input  rd_data, rd_valid, swap_pending, prof_valid, wr_drop
  );

  modport slave (
`ifdef WAVE_SCROLL_EN
    input  scroll_off,
`endif
    input  wr_en, wr_index, wr_value, wave_ready, frame_start, rd_req, rd_index,
    output rd_data, rd_valid, swap_pending, prof_valid, wr_drop
  );
endinterface

// File: rtl/wave_prof_reader.sv
// Double-buffered wave-profile store: back bank filled by the calculator, front
// bank read by the display with 2-cycle latency. Optional macro: WAVE_SCROLL_EN.
module wave_prof_reader #(
  parameter int LOG_WIDTH = 10,
  parameter int WIDTH     = 1024,
  parameter int RESOL     = 10
) (
  input  logic       clock,
  input  logic       reset,
  wave_prof_if.slave bus
);
  localparam logic [LOG_WIDTH:0] WIDTH_L = (LOG_WIDTH+1)'(WIDTH);

  typedef enum logic [1:0] {EMPTY, SHOW, PENDING} state_t;

  state_t           state_q, state_d;
  logic             front_sel;
  logic             prof_valid_q;
  logic             wr_drop_q;
  logic             do_swap, wr_ok, drop_set, wr_bank;
  logic [RESOL-1:0] mem [2**(LOG_WIDTH+1)];

  always_comb begin
    state_d  = state_q;
    do_swap  = 1'b0;
    wr_ok    = 1'b0;
    drop_set = 1'b0;
    case (state_q)
      PENDING: begin
        if (bus.frame_start) begin
          do_swap = 1'b1;
          wr_ok   = 1'b1;
          state_d = SHOW;
        end else if (bus.wr_en) begin
          drop_set = 1'b1;
        end
      end
      default: begin
        wr_ok = 1'b1;
        if (bus.wave_ready) begin
          if (bus.frame_start) begin
            do_swap = 1'b1;
            state_d = SHOW;
          end else begin
            state_d = PENDING;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      front_sel    <= 1'b0;
      prof_valid_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_swap) begin
        front_sel    <= ~front_sel;
        prof_valid_q <= 1'b1;
      end
      if (drop_set) wr_drop_q <= 1'b1;
    end
  end

  // In the swap cycle out of PENDING the old front becomes the back bank.
  assign wr_bank = (state_q == PENDING) ? front_sel : ~front_sel;

  always_ff @(posedge clock) begin
    if (bus.wr_en && wr_ok && ({1'b0, bus.wr_index} < WIDTH_L))
      mem[{wr_bank, bus.wr_index}] <= bus.wr_value;
  end

`ifdef WAVE_SCROLL_EN
  logic [LOG_WIDTH-1:0] scroll_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                scroll_q <= '0;
    else if (bus.frame_start)  scroll_q <= bus.scroll_off;
  end
`endif

  // Stage 1: request captured with the bank and validity in force at request time
  logic                 vld_p1, bank_p1, pv_p1;
  logic [LOG_WIDTH-1:0] idx_p1;
  logic [LOG_WIDTH:0]   eff_p1;
  logic                 hit_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= bus.rd_req;
  end

  always_ff @(posedge clock) begin
    idx_p1  <= bus.rd_index;
    bank_p1 <= front_sel;
    pv_p1   <= prof_valid_q;
  end

  always_comb begin
    eff_p1 = {1'b0, idx_p1};
`ifdef WAVE_SCROLL_EN
    eff_p1 = {1'b0, idx_p1} + {1'b0, scroll_q};
    if (eff_p1 >= WIDTH_L) eff_p1 = eff_p1 - WIDTH_L;
`endif
  end

  // Every committed bank has entry 0 forced to zero, so index 0 never needs the RAM.
  assign hit_p1 = vld_p1 && pv_p1 && (eff_p1 < WIDTH_L) && (eff_p1 != '0);

  // Stage 2: registered RAM read, zero whenever the result is not valid
  logic             vld_p2;
  logic [RESOL-1:0] data_p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      data_p2 <= hit_p1 ? mem[{bank_p1, eff_p1[LOG_WIDTH-1:0]}] : '0;
    end
  end

  assign bus.rd_valid     = vld_p2;
  assign bus.rd_data      = data_p2;
  assign bus.swap_pending = (state_q == PENDING);
  assign bus.prof_valid   = prof_valid_q;
  assign bus.wr_drop      = wr_drop_q;
endmodule

// File: tb/tb_wave_prof_reader.sv
// Self-checking bench for wave_prof_reader: randomized traffic against a
// profile-level reference model (front/back arrays swapped as whole profiles).
module tb_wave_prof_reader;
  localparam int LW = 10;
  localparam int W  = 1024;
  localparam int RS = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  wave_prof_if #(.LOG_WIDTH(LW), .RESOL(RS)) bus ();

  wave_prof_reader #(.LOG_WIDTH(LW), .WIDTH(W), .RESOL(RS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int m_front [W];
  int m_back  [W];
  bit m_pend, m_pv, m_drop;
  int m_scroll;
  bit d1v, exp_v;
  int d1d, exp_d;

  task automatic model_reset();
    m_pend = 0; m_pv = 0; m_drop = 0; m_scroll = 0;
    d1v = 0; d1d = 0; exp_v = 0; exp_d = 0;
  endtask

  task automatic swap_model();
    int t;
    for (int k = 0; k < W; k++) begin
      t = m_front[k]; m_front[k] = m_back[k]; m_back[k] = t;
    end
    m_pv = 1;
  endtask

  // Drives one cycle, advances the model; exp_v/exp_d = what rd_* must show now.
  task automatic step(input bit we, input int wi, input int wv, input bit wr,
                      input bit fs, input bit rq, input int ri, input int so);
    int eff, nd;
    bit nv;
    bus.wr_en = we; bus.wr_index = LW'(wi); bus.wr_value = RS'(wv);
    bus.wave_ready = wr; bus.frame_start = fs;
    bus.rd_req = rq; bus.rd_index = LW'(ri);
`ifdef WAVE_SCROLL_EN
    bus.scroll_off = LW'(so);
    eff = (ri + m_scroll) % W;
`else
    eff = ri;
`endif
    nv = rq;
    nd = (rq && m_pv && eff < W) ? m_front[eff] : 0;
    @(posedge clock); #1;
    if (!m_pend) begin
      if (we && wi < W) m_back[wi] = wv;
      if (wr) begin
        m_back[0] = 0;
        if (fs) swap_model(); else m_pend = 1;
      end
    end else if (fs) begin
      swap_model();
      m_pend = 0;
      if (we && wi < W) m_back[wi] = wv;
    end else if (we) begin
      m_drop = 1;
    end
    if (fs) m_scroll = so;
    exp_v = d1v; exp_d = d1d;
    d1v = nv; d1d = nd;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int idx);
    step(0, 0, 0, 0, 0, 1, idx, 0);
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_index = '0; bus.wr_value = '0; bus.wave_ready = 0;
    bus.frame_start = 0; bus.rd_req = 0; bus.rd_index = '0;
`ifdef WAVE_SCROLL_EN
    bus.scroll_off = '0;
`endif
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data got %0d want 0", bus.rd_data); end
    n_cmp++; if (bus.swap_pending !== 1'b0) begin n_bad++; $display("FAIL reset_swap_pending got %b want 0", bus.swap_pending); end
    n_cmp++; if (bus.prof_valid !== 1'b0) begin n_bad++; $display("FAIL reset_prof_valid got %b want 0", bus.prof_valid); end
    n_cmp++; if (bus.wr_drop !== 1'b0) begin n_bad++; $display("FAIL reset_wr_drop got %b want 0", bus.wr_drop); end
    #3 reset = 1'b1;
    model_reset();
    rd(5);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_latency1 rd_valid got %b want 0", bus.rd_valid); end
    idle();
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL empty_latency2 rd_valid got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL empty_rd_data got %0d want 0", bus.rd_data); end
    n_cmp++; if (bus.prof_valid !== 1'b0) begin n_bad++; $display("FAIL empty_prof_valid got %b want 0", bus.prof_valid); end
    idle();
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL empty_single_result rd_valid got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_profile_swap();
    int idxs [3];
    int r;
    idxs[0] = 0; idxs[1] = 7; idxs[2] = 1023;
    for (int i = 1; i < W; i++) step(1, i, i, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (bus.swap_pending !== 1'b1) begin n_bad++; $display("FAIL commit_swap_pending got %b want 1", bus.swap_pending); end
    idle();
    n_cmp++; if (bus.swap_pending !== 1'b1) begin n_bad++; $display("FAIL hold_swap_pending got %b want 1", bus.swap_pending); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (bus.swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_clears_pending got %b want 0", bus.swap_pending); end
    n_cmp++; if (bus.prof_valid !== 1'b1) begin n_bad++; $display("FAIL swap_prof_valid got %b want 1", bus.prof_valid); end
    for (int k = 0; k < 3; k++) begin
      rd(idxs[k]); idle();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== RS'(idxs[k])) begin
        n_bad++; $display("FAIL prof1_read idx %0d got v=%b d=%0d want v=1 d=%0d", idxs[k], bus.rd_valid, bus.rd_data, idxs[k]);
      end
    end
    for (int k = 0; k < 22; k++) begin
      r = $urandom_range(0, W - 1);
      if (k < 20) rd(r); else idle();
      n_cmp++;
      if (bus.rd_valid !== exp_v || bus.rd_data !== RS'(exp_d)) begin
        n_bad++; $display("FAIL prof1_random got v=%b d=%0d want v=%b d=%0d", bus.rd_valid, bus.rd_data, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_no_early_swap();
    for (int i = 1; i < W; i++) step(1, i, 1023 - i, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (bus.swap_pending !== 1'b1) begin n_bad++; $display("FAIL prof2_pending got %b want 1", bus.swap_pending); end
    rd(7); idle();
    n_cmp++; if (bus.rd_data !== RS'(7)) begin n_bad++; $display("FAIL prof2_old_front got %0d want 7", bus.rd_data); end
    for (int k = 0; k < 12; k++) begin
      if (k < 10) rd($urandom_range(0, W - 1)); else idle();
      n_cmp++;
      if (bus.rd_valid !== exp_v || bus.rd_data !== RS'(exp_d)) begin
        n_bad++; $display("FAIL pending_random got v=%b d=%0d want v=%b d=%0d", bus.rd_valid, bus.rd_data, exp_v, exp_d);
      end
    end
    n_cmp++; if (bus.wr_drop !== 1'b0) begin n_bad++; $display("FAIL wr_drop_before got %b want 0", bus.wr_drop); end
    step(1, 7, 555, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.wr_drop !== 1'b1) begin n_bad++; $display("FAIL wr_drop_set got %b want 1", bus.wr_drop); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (bus.swap_pending !== 1'b0) begin n_bad++; $display("FAIL prof2_swap_pending got %b want 0", bus.swap_pending); end
    rd(7); idle();
    n_cmp++; if (bus.rd_data !== RS'(1016)) begin n_bad++; $display("FAIL prof2_read7 got %0d want 1016", bus.rd_data); end
    n_cmp++; if (bus.wr_drop !== 1'b1) begin n_bad++; $display("FAIL wr_drop_sticky got %b want 1", bus.wr_drop); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    bit saw_pending;
    nvalid = 0; saw_pending = 0;
    for (int i = 1; i < W; i++) step(1, i, $urandom_range(0, W - 1), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    if (bus.swap_pending) saw_pending = 1;
    n_cmp++; if (bus.prof_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_prof_valid got %b want 1", bus.prof_valid); end
    for (int k = 0; k < 18; k++) begin
      if (k < 16) rd(k); else idle();
      if (bus.swap_pending) saw_pending = 1;
      if (bus.rd_valid) nvalid++;
      n_cmp++;
      if (bus.rd_valid !== exp_v || bus.rd_data !== RS'(exp_d)) begin
        n_bad++; $display("FAIL b2b_stream k=%0d got v=%b d=%0d want v=%b d=%0d", k, bus.rd_valid, bus.rd_data, exp_v, exp_d);
      end
    end
    n_cmp++; if (saw_pending !== 1'b0) begin n_bad++; $display("FAIL b2b_swap_pending_seen got %b want 0", saw_pending); end
    n_cmp++; if (nvalid != 16) begin n_bad++; $display("FAIL b2b_result_count got %0d want 16", nvalid); end
  endtask

  task automatic test_random();
    bit we, wr, fs, rq;
    for (int c = 0; c < 400; c++) begin
      we = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 39) == 0);
      fs = ($urandom_range(0, 29) == 0);
      rq = fs ? 1'b0 : ($urandom_range(0, 1) == 1);
      step(we, $urandom_range(0, W - 1), $urandom_range(0, W - 1), wr, fs, rq,
           $urandom_range(0, W - 1), $urandom_range(0, W - 1));
      n_cmp++;
      if (bus.rd_valid !== exp_v || bus.rd_data !== RS'(exp_d) || bus.swap_pending !== m_pend ||
          bus.prof_valid !== m_pv || bus.wr_drop !== m_drop) begin
        n_bad++;
        $display("FAIL random c=%0d got v=%b d=%0d sp=%b pv=%b dr=%b want v=%b d=%0d sp=%b pv=%b dr=%b",
                 c, bus.rd_valid, bus.rd_data, bus.swap_pending, bus.prof_valid, bus.wr_drop,
                 exp_v, exp_d, m_pend, m_pv, m_drop);
      end
    end
    idle(); idle();
  endtask

`ifdef WAVE_SCROLL_EN
  task automatic test_scroll();
    step(0, 0, 0, 0, 1, 0, 0, 1020);
    step(0, 0, 0, 0, 1, 0, 0, 1020);
    rd(10); idle();
    n_cmp++; if (bus.rd_data !== RS'(m_front[6]) || bus.rd_data !== RS'(exp_d)) begin
      n_bad++; $display("FAIL scroll_idx10 got %0d want %0d", bus.rd_data, m_front[6]);
    end
    rd(2); idle();
    n_cmp++; if (bus.rd_data !== RS'(m_front[1022])) begin
      n_bad++; $display("FAIL scroll_idx2 got %0d want %0d", bus.rd_data, m_front[1022]);
    end
    rd(4); idle();
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL scroll_wrap_entry0 got %0d want 0", bus.rd_data); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 1; i < 8; i++) step(1, i, i + 100, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    rd(3); rd(4); rd(5);
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.swap_pending !== 1'b1) begin
      n_bad++; $display("FAIL prereset got v=%b sp=%b want v=1 sp=1", bus.rd_valid, bus.swap_pending);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL async_rd_valid got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL async_rd_data got %0d want 0", bus.rd_data); end
    n_cmp++; if (bus.swap_pending !== 1'b0) begin n_bad++; $display("FAIL async_swap_pending got %b want 0", bus.swap_pending); end
    n_cmp++; if (bus.prof_valid !== 1'b0) begin n_bad++; $display("FAIL async_prof_valid got %b want 0", bus.prof_valid); end
    n_cmp++; if (bus.wr_drop !== 1'b0) begin n_bad++; $display("FAIL async_wr_drop got %b want 0", bus.wr_drop); end
    bus.rd_req = 0; bus.wave_ready = 0; bus.wr_en = 0;
    repeat (2) @(posedge clock);
    #4 reset = 1'b1;
    model_reset();
    rd(5); idle();
    n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== '0) begin
      n_bad++; $display("FAIL post_reset_read got v=%b d=%0d want v=1 d=0", bus.rd_valid, bus.rd_data);
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < W; k++) begin m_front[k] = 0; m_back[k] = 0; end
    test_reset();
    test_profile_swap();
    test_no_early_swap();
    test_back_to_back();
    test_random();
`ifdef WAVE_SCROLL_EN
    test_scroll();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
